// File: rtl/adc_window_sum_if.sv
// Sample-stream and result bundle for the ADC moving-window summer.
// adc_valid qualifies adc_data for one cycle; there is no ready, the block accepts every valid sample.
interface adc_window_sum_if #(
  parameter int DATA_W = 10,
  parameter int WIN_W  = 8,
  parameter int SUM_W  = 20
);
  logic              start;
  logic [WIN_W-1:0]  window_width;
  logic [DATA_W-1:0] adc_data;
  logic              adc_valid;
  logic [SUM_W-1:0]  sum_out;
  logic              sum_valid;
  logic              filled;
  logic              cfg_err;

  modport master (
    output start, window_width, adc_data, adc_valid,
    input  sum_out, sum_valid, filled, cfg_err
  );

  modport slave (
    input  start, window_width, adc_data, adc_valid,
    output sum_out, sum_valid, filled, cfg_err
  );
endinterface

// File: rtl/adc_window_sum.sv
// Streaming moving-window summer: ring buffer of the last N samples, running sum
// updated incrementally (add newest, subtract oldest). N latched at run start.
module adc_window_sum #(
  parameter int DATA_W = 10,
  parameter int WIN_W  = 8,
  parameter int SUM_W  = 20
) (
  input  logic                 clk,
  input  logic                 reset,
  adc_window_sum_if.slave      bus,
  output logic [1:0]           state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2,
    ERR  = 2'd3
  } state_t;

  localparam logic [WIN_W-1:0] ONE_W = {{(WIN_W-1){1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic [WIN_W-1:0]  n_q, wp_q, cnt_q, cnt_inc, rd_idx;
  logic [SUM_W-1:0]  acc_q, acc_d, sum_q, sample_ext, oldest_ext;
  logic              sum_valid_q;
  logic              start_run, wr_en, cnt_en, sum_ld, clr_out;
  logic [DATA_W-1:0] mem [0:(1<<WIN_W)-1];

  // Async read of the oldest sample sees the pre-write contents, so a wrap onto
  // the write slot subtracts the old value.
  assign rd_idx     = wp_q - n_q;
  assign cnt_inc    = cnt_q + ONE_W;
  assign sample_ext = {{(SUM_W-DATA_W){1'b0}}, bus.adc_data};
  assign oldest_ext = {{(SUM_W-DATA_W){1'b0}}, mem[rd_idx]};

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    start_run = 1'b0;
    wr_en     = 1'b0;
    cnt_en    = 1'b0;
    sum_ld    = 1'b0;
    clr_out   = 1'b0;
    acc_d     = acc_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.window_width != '0) begin
            state_d   = FILL;
            start_run = 1'b1;
          end else begin
            state_d = ERR;
          end
        end
      end
      FILL: begin
        if (!bus.start) begin
          state_d = IDLE;
          clr_out = 1'b1;
        end else if (bus.adc_valid) begin
          wr_en  = 1'b1;
          cnt_en = 1'b1;
          acc_d  = acc_q + sample_ext;
          if (cnt_inc == n_q) begin
            state_d = RUN;
            sum_ld  = 1'b1;
          end
        end
      end
      RUN: begin
        if (!bus.start) begin
          state_d = IDLE;
          clr_out = 1'b1;
        end else if (bus.adc_valid) begin
          wr_en  = 1'b1;
          acc_d  = acc_q + sample_ext - oldest_ext;
          sum_ld = 1'b1;
        end
      end
      ERR: begin
        if (!bus.start) begin
          state_d = IDLE;
          clr_out = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      n_q         <= '0;
      wp_q        <= '0;
      cnt_q       <= '0;
      acc_q       <= '0;
      sum_q       <= '0;
      sum_valid_q <= 1'b0;
    end else begin
      sum_valid_q <= sum_ld;
      if (start_run) begin
        n_q   <= bus.window_width;
        wp_q  <= '0;
        cnt_q <= '0;
        acc_q <= '0;
      end
      if (wr_en) begin
        acc_q <= acc_d;
        wp_q  <= wp_q + ONE_W;
      end
      if (cnt_en) cnt_q <= cnt_inc;
      if (sum_ld) sum_q <= acc_d;
      else if (clr_out) sum_q <= '0;
    end
  end

  // Buffer contents are never read before being written in the current run.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wp_q] <= bus.adc_data;
  end

  assign bus.sum_out   = sum_q;
  assign bus.sum_valid = sum_valid_q;
  assign bus.filled    = (state_q == RUN);
  assign bus.cfg_err   = (state_q == ERR);
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_adc_window_sum.sv
// Bench for adc_window_sum: queue-based window model checked every cycle, plus
// hand-computed sums for the directed scenarios.
module tb_adc_window_sum;
  localparam int DATA_W = 10;
  localparam int WIN_W  = 8;
  localparam int SUM_W  = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] state_dbg;

  adc_window_sum_if #(.DATA_W(DATA_W), .WIN_W(WIN_W), .SUM_W(SUM_W)) bus ();

  adc_window_sum #(.DATA_W(DATA_W), .WIN_W(WIN_W), .SUM_W(SUM_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  logic [SUM_W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // model: 0 = stopped, 1 = running (filling or full), 2 = config error
  int          m_mode = 0;
  int          m_n = 0;
  int unsigned hist[$];
  int unsigned m_acc;
  logic [SUM_W-1:0] m_sum = '0;
  bit          m_valid = 1'b0;
  bit          m_live = 1'b0;

  always @(posedge clk) begin
    m_live  = 1'b1;
    m_valid = 1'b0;
    if (reset) begin
      m_mode = 0;
      hist.delete();
      m_sum = '0;
    end else begin
      case (m_mode)
        0: if (bus.start) begin
          if (bus.window_width == 0) m_mode = 2;
          else begin
            m_mode = 1;
            m_n = int'(bus.window_width);
            hist.delete();
          end
        end
        1: if (!bus.start) begin
          m_mode = 0;
          m_sum = '0;
          hist.delete();
        end else if (bus.adc_valid) begin
          hist.push_back(int'(bus.adc_data));
          if (hist.size() > 256) void'(hist.pop_front());
          if (hist.size() >= m_n) begin
            m_acc = 0;
            for (int i = 0; i < m_n; i++) m_acc += hist[hist.size() - 1 - i];
            m_sum = SUM_W'(m_acc);
            m_valid = 1'b1;
          end
        end
        default: if (!bus.start) m_mode = 0;
      endcase
    end
  end

  // scoreboard: every-cycle model compare, plus literal sums on strobes
  always @(negedge clk) begin
    if (m_live) begin
      chk("sum_valid", 32'(bus.sum_valid), 32'(m_valid));
      chk("sum_out", 32'(bus.sum_out), 32'(m_sum));
      chk("filled", 32'(bus.filled), 32'(m_mode == 1 && hist.size() >= m_n));
      chk("cfg_err", 32'(bus.cfg_err), 32'(m_mode == 2));
      if (bus.sum_valid === 1'b1 && exp_q.size() > 0)
        chk("lit_sum", 32'(bus.sum_out), 32'(exp_q.pop_front()));
    end
  end

  // driver tasks
  task automatic cyc(input bit s, input int ww, input int d, input bit v);
    @(negedge clk);
    bus.start        = s;
    bus.window_width = WIN_W'(ww);
    bus.adc_data     = DATA_W'(d);
    bus.adc_valid    = v;
  endtask

  task automatic stop2();
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
  endtask

  task automatic drain(input string name);
    chk(name, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    bus.start = 1'b0; bus.window_width = '0; bus.adc_data = '0; bus.adc_valid = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_state", 32'(state_dbg), 32'd0);
    chk("rst_sum_out", 32'(bus.sum_out), 32'd0);
    chk("rst_filled", 32'(bus.filled), 32'd0);
    reset = 1'b0;

    // N=4, continuous samples 1..6; sample on the start cycle is ignored
    cyc(1, 4, 99, 1);
    exp_q.push_back(10); exp_q.push_back(14); exp_q.push_back(18);
    for (int i = 1; i <= 6; i++) cyc(1, 4, i, 1);
    cyc(1, 4, 0, 0);
    @(posedge clk) #1;
    chk("t1_filled", 32'(bus.filled), 32'd1);
    chk("t1_hold", 32'(bus.sum_out), 32'd18);
    stop2();
    drain("t1_drain");

    // N=4, gaps between samples
    cyc(1, 4, 99, 1);
    exp_q.push_back(10); exp_q.push_back(14); exp_q.push_back(18);
    for (int i = 1; i <= 6; i++) begin
      cyc(1, 4, i, 1);
      cyc(1, 4, 777, 0);
    end
    stop2();
    drain("t2_drain");

    // N=255, constant full-scale through the pointer wrap
    cyc(1, 255, 0, 0);
    for (int i = 0; i < 46; i++) exp_q.push_back(260865);
    repeat (300) cyc(1, 255, 1023, 1);
    cyc(1, 255, 0, 0);
    @(posedge clk) #1;
    chk("t3_hold", 32'(bus.sum_out), 32'd260865);
    stop2();
    drain("t3_drain");

    // N=1
    cyc(1, 1, 0, 0);
    exp_q.push_back(7); exp_q.push_back(0); exp_q.push_back(1023);
    cyc(1, 1, 7, 1);
    cyc(1, 1, 0, 1);
    cyc(1, 1, 1023, 1);
    stop2();
    drain("t4_drain");

    // mid-run restart: history of 9s must not leak into the new window
    cyc(1, 3, 0, 0);
    exp_q.push_back(27); exp_q.push_back(27); exp_q.push_back(2);
    repeat (4) cyc(1, 3, 9, 1);
    cyc(0, 2, 9, 1);
    @(posedge clk) #1;
    chk("t5_clear_sum", 32'(bus.sum_out), 32'd0);
    chk("t5_clear_filled", 32'(bus.filled), 32'd0);
    cyc(1, 2, 9, 1);
    cyc(1, 2, 1, 1);
    cyc(1, 2, 1, 1);
    cyc(1, 2, 0, 0);
    stop2();
    drain("t5_drain");

    // window_width == 0
    cyc(1, 0, 5, 1);
    repeat (20) cyc(1, 0, 5, 1);
    @(posedge clk) #1;
    chk("t6_cfg_err", 32'(bus.cfg_err), 32'd1);
    chk("t6_state", 32'(state_dbg), 32'd3);
    cyc(0, 0, 0, 0);
    @(posedge clk) #1;
    chk("t6_cfg_clear", 32'(bus.cfg_err), 32'd0);

    // reset mid-fill
    cyc(1, 8, 0, 0);
    repeat (3) cyc(1, 8, 3, 1);
    @(posedge clk) #1;
    chk("t7_in_fill", 32'(state_dbg), 32'd1);
    @(negedge clk);
    reset = 1'b1; bus.start = 1'b1; bus.adc_valid = 1'b1;
    @(posedge clk) #1;
    chk("t7_state", 32'(state_dbg), 32'd0);
    chk("t7_sum_valid", 32'(bus.sum_valid), 32'd0);
    chk("t7_sum_out", 32'(bus.sum_out), 32'd0);
    @(negedge clk);
    reset = 1'b0; bus.start = 1'b0; bus.adc_valid = 1'b0;
    stop2();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
